serial_addsub: RTL and testbench
================================

# serial_addsub

Parametrised multi-cycle adder/subtractor, the successor to the 4-bit ripple adder. It accepts two WIDTH-bit operands through a valid/ready handshake and adds or subtracts them CHUNK bits per clock, LSB chunk first, with the carry held in a register between chunks. The result, carry/borrow and signed overflow are held until the consumer accepts them. It is the area-economical arithmetic unit for datapaths where wide operands do not need single-cycle results.

## Interface
- WIDTH, 16, operand/result width; must be a positive multiple of CHUNK
- CHUNK, 4, bits added per clock; NCH = WIDTH/CHUNK chunk cycles per operation
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and mode presented
- in_ready  output  1  block can accept; equals (state == IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0: a+b+cin; 1: a-b-cin (cin acts as borrow-in)
- cin  input  1  carry-in (add) / borrow-in (sub)
- out_valid  output  1  result registers hold a completed result
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry out of MSB; in sub mode 1 = no borrow, 0 = borrow
- ovf  output  1  two's-complement signed overflow

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE, chunk counter 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0. in_ready is 1 while in IDLE, including while reset is held; inputs are ignored while reset is high.
- IDLE: on in_valid && in_ready, latch a, and latch b' = sub ? ~b : b. Set carry = sub ? ~cin : cin. Clear counter. Go to RUN. sum is not cleared at accept.
- RUN: each cycle, for chunk k = counter, compute {c, s} = a[k] + b'[k] + carry, CHUNK+1 bits wide. Write s into sum[k*CHUNK +: CHUNK]. Set carry = c. Increment counter.
- Last chunk (counter == NCH-1):
  - cout = c
  - ovf = (a_msb == b'_msb) && (s_msb != a_msb)
  - Go to DONE.
- DONE: out_valid = 1. sum, cout and ovf are stable. in_ready = 0.
  - On out_ready, go to IDLE on the same edge; out_valid drops.
  - sum, cout and ovf keep their values until the next operation overwrites them.
- in_valid while not in IDLE is ignored. No input queuing, no back-to-back overlap.
- Subtract identity: a - b - cin = a + ~b + (1 - cin).
- CHUNK == WIDTH is legal and gives a single RUN cycle.

## Timing
- Accept on edge E0. RUN occupies edges E1..E(NCH). out_valid is high after edge E(NCH).
  - Latency is NCH cycles from accept to out_valid (4 for the defaults).
  - The earliest next accept is 1 cycle after the out_valid/out_ready handshake.
- sum chunks fill progressively during RUN. The final values are guaranteed only while out_valid = 1.
- Reset asserted mid-RUN or in DONE returns all state to reset values immediately, without waiting for a clock edge. The partial result is discarded. The first operation after reset deassertion must be correct.
- out_ready held in IDLE or RUN has no effect.
- Throughput: one operation per NCH+2 cycles when out_ready is held high.

## Test plan
- Basic add (defaults): a=0x1234, b=0x1111, sub=0, cin=0 -> sum=0x2345, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- Carry across all chunks: a=0xFFFF, b=0x0001, add -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract cases:
  - a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0, ovf=0
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1
  - a=0x0010, b=0x0003, sub=1, cin=1 -> sum=0x000C, cout=1
- Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with new operands.
  - Required: sum, cout, ovf and out_valid stay stable; in_ready stays 0; new operands are not taken.
  - On out_ready=1: IDLE on the next edge, in_ready=1.
- Reset mid-operation: assert reset 2 cycles into RUN.
  - Required: immediately state=IDLE, out_valid=0, sum=0, cout=0, ovf=0.
  - After release: a=0x00FF, b=0x0001, add -> sum=0x0100 after 4 cycles.
- Parameter sweep: with WIDTH=16, CHUNK=16, a=0xFFFF, b=0xFFFF -> sum=0xFFFE, cout=1, latency 1 cycle. Random add/sub against a reference model for WIDTH=32, CHUNK=8, with latency 4.

Source files
------------

// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub: operands in via in_valid/in_ready,
// result out via out_valid/out_ready; result fields are held while out_valid is high.
interface serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle add/sub, CHUNK bits per clock LSB first; result valid WIDTH/CHUNK cycles after accept.
// Result is held in DONE until out_ready; no new operands are taken until the result is consumed.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           reset,
    serial_addsub_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_add;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_ovf_nxt;

    // r_b already holds ~b in subtract mode, so the datapath only ever adds.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_cnt == CW'(k)) begin
                w_a_chunk = r_a[k*CHUNK +: CHUNK];
                w_b_chunk = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    assign w_add  = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    assign w_last = (r_cnt == CW'(NCH - 1));

    always_comb begin
        w_sum_nxt = r_sum;
        for (int k = 0; k < NCH; k++) begin
            if (r_cnt == CW'(k)) begin
                w_sum_nxt[k*CHUNK +: CHUNK] = w_add[CHUNK-1:0];
            end
        end
    end

    // Signed overflow: operands agree in sign but the result's sign differs.
    assign w_ovf_nxt = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[CHUNK-1] != r_a[WIDTH-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? ~bus.cin : bus.cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_sum   <= w_sum_nxt;
            r_carry <= w_add[CHUNK];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_add[CHUNK];
                r_ovf  <= w_ovf_nxt;
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: default 16/4, single-chunk 16/16 and 32/8 instances share clk/reset.
module tb_serial_addsub;
    logic clk;
    logic reset;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    serial_addsub_if #(.WIDTH(16)) if0 ();
    serial_addsub_if #(.WIDTH(16)) if1 ();
    serial_addsub_if #(.WIDTH(32)) if2 ();

    serial_addsub #(.WIDTH(16), .CHUNK(4))  u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    serial_addsub #(.WIDTH(16), .CHUNK(16)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    serial_addsub #(.WIDTH(32), .CHUNK(8))  u_dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        return e;
    endfunction

    // Whole-word reference: a + (sub ? ~b : b) + (sub ? ~cin : cin) at width w.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic cin);
        logic [63:0] mask, aa, bb, full;
        exp_t e;
        mask   = (64'd1 << w) - 64'd1;
        aa     = {32'h0, a} & mask;
        bb     = (sub ? ~{32'h0, b} : {32'h0, b}) & mask;
        full   = aa + bb + {63'd0, (sub ? ~cin : cin)};
        e.sum  = 32'(full & mask);
        e.cout = full[w];
        e.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        return e;
    endfunction

    function automatic int nch_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic g_ir(input int i);
        case (i)
            0:       return if0.in_ready;
            1:       return if1.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    function automatic logic g_ov(input int i);
        case (i)
            0:       return if0.out_valid;
            1:       return if1.out_valid;
            default: return if2.out_valid;
        endcase
    endfunction

    function automatic logic [31:0] g_sum(input int i);
        case (i)
            0:       return {16'h0, if0.sum};
            1:       return {16'h0, if1.sum};
            default: return if2.sum;
        endcase
    endfunction

    function automatic logic g_cout(input int i);
        case (i)
            0:       return if0.cout;
            1:       return if1.cout;
            default: return if2.cout;
        endcase
    endfunction

    function automatic logic g_ovf(input int i);
        case (i)
            0:       return if0.ovf;
            1:       return if1.ovf;
            default: return if2.ovf;
        endcase
    endfunction

    task automatic drive(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic c);
        case (i)
            0: begin
                if0.in_valid = v; if0.a = a[15:0]; if0.b = b[15:0]; if0.sub = s; if0.cin = c;
            end
            1: begin
                if1.in_valid = v; if1.a = a[15:0]; if1.b = b[15:0]; if1.sub = s; if1.cin = c;
            end
            default: begin
                if2.in_valid = v; if2.a = a; if2.b = b; if2.sub = s; if2.cin = c;
            end
        endcase
    endtask

    task automatic set_ordy(input int i, input logic v);
        case (i)
            0:       if0.out_ready = v;
            1:       if1.out_ready = v;
            default: if2.out_ready = v;
        endcase
    endtask

    // Accept an operation, push its expectation and measure cycles to out_valid.
    task automatic start(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic c, input exp_t e);
        int  n;
        bit  seen;
        n = 0;
        while (g_ir(i) !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_accept", {31'h0, g_ir(i)}, 32'd1);
        drive(i, 1'b1, a, b, s, c);
        sb.push_back(e);
        @(posedge clk); #1;
        drive(i, 1'b0, a, b, s, c);
        chk("in_ready_after_accept", {31'h0, g_ir(i)}, 32'd0);
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            if (g_ov(i) === 1'b1) begin
                seen = 1;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("latency", n, nch_of(i));
    endtask

    task automatic finish(input int i);
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("sum", g_sum(i), e.sum);
            chk("cout", {31'h0, g_cout(i)}, {31'h0, e.cout});
            chk("ovf", {31'h0, g_ovf(i)}, {31'h0, e.ovf});
        end
        set_ordy(i, 1'b1);
        @(posedge clk); #1;
        set_ordy(i, 1'b0);
        chk("out_valid_after_hs", {31'h0, g_ov(i)}, 32'd0);
        chk("in_ready_after_hs", {31'h0, g_ir(i)}, 32'd1);
    endtask

    task automatic run(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic c, input exp_t e);
        start(i, a, b, s, c, e);
        finish(i);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs, rc;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            set_ordy(i, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, if0.in_ready}, 32'd1);
        chk("rst_out_valid", {31'h0, if0.out_valid}, 32'd0);
        chk("rst_sum", {16'h0, if0.sum}, 32'h0);
        chk("rst_cout", {31'h0, if0.cout}, 32'd0);
        chk("rst_ovf", {31'h0, if0.ovf}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run(0, 32'h1234, 32'h1111, 1'b0, 1'b0, mk(32'h2345, 1'b0, 1'b0));
        run(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, mk(32'h8000, 1'b0, 1'b1));
        run(0, 32'h0005, 32'h0007, 1'b1, 1'b0, mk(32'hFFFE, 1'b0, 1'b0));
        run(0, 32'h0010, 32'h0003, 1'b1, 1'b1, mk(32'h000C, 1'b1, 1'b0));

        // Backpressure: result must hold while new operands are offered and refused.
        start(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, mk(32'h0000, 1'b1, 1'b0));
        for (int k = 0; k < 10; k++) begin
            drive(0, 1'b1, 32'hAAAA, 32'h5555, k[0], 1'b1);
            @(posedge clk); #1;
            chk("bp_out_valid", {31'h0, if0.out_valid}, 32'd1);
            chk("bp_in_ready", {31'h0, if0.in_ready}, 32'd0);
            chk("bp_sum", {16'h0, if0.sum}, 32'h0000);
            chk("bp_cout", {31'h0, if0.cout}, 32'd1);
            chk("bp_ovf", {31'h0, if0.ovf}, 32'd0);
        end
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        finish(0);
        @(posedge clk); #1;
        chk("bp_not_taken_in_ready", {31'h0, if0.in_ready}, 32'd1);

        // Leaves cout=1/ovf=1 so the async clear below is observable.
        run(0, 32'h8000, 32'h0001, 1'b1, 1'b0, mk(32'h7FFF, 1'b1, 1'b1));

        drive(0, 1'b1, 32'h1234, 32'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'h0, if0.in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'h0, if0.out_valid}, 32'd0);
        chk("mid_rst_sum", {16'h0, if0.sum}, 32'h0);
        chk("mid_rst_cout", {31'h0, if0.cout}, 32'd0);
        chk("mid_rst_ovf", {31'h0, if0.ovf}, 32'd0);
        drive(0, 1'b1, 32'h4444, 32'h4444, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ignores_in_valid", {31'h0, if0.in_ready}, 32'd1);
        chk("rst_sum_held", {16'h0, if0.sum}, 32'h0);
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        run(0, 32'h00FF, 32'h0001, 1'b0, 1'b0, mk(32'h0100, 1'b0, 1'b0));

        run(1, 32'hFFFF, 32'hFFFF, 1'b0, 1'b0, mk(32'hFFFE, 1'b1, 1'b0));
        run(1, 32'h8000, 32'h0001, 1'b1, 1'b0, mk(32'h7FFF, 1'b1, 1'b1));

        for (int k = 0; k < 24; k++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            run(2, ra, rb, rs, rc, model(32, ra, rb, rs, rc));
        end
        run(2, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, mk(32'h80000000, 1'b0, 1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
